proc_hazard_unit: RTL and testbench

PROC_HAZARD_UNIT -- requirements
Module: proc_hazard_unit

---
 rtl/proc_hazard_pkg.sv | 17 +
 rtl/proc_hazard_match.sv | 50 +++++
 rtl/proc_hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_proc_hazard_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_hazard_pkg.sv
// proc_hazard_pkg
// Shared definitions for the pipeline hazard unit: the stage-index type
// (sized for the deepest legal pipeline) and the named stage constants.
//   NONE    : no bypass source, operand comes from the register file
//   AVAIL_X : result bypassable from stage 1 (ALU result)
//   AVAIL_M : result bypassable from stage 2 (load data)
package proc_hazard_pkg;

  localparam int STG_MAX_W = 3;

  typedef logic [STG_MAX_W-1:0] stg_t;

  localparam stg_t NONE    = 3'd0;
  localparam stg_t AVAIL_X = 3'd1;
  localparam stg_t AVAIL_M = 3'd2;

endpackage

// File: rtl/proc_hazard_match.sv
// proc_hazard_match
// Youngest-producer search for one source operand.
//   en, rs       : source read enable and register address
//   val, wen     : per-stage valid / writes-RF flags (bit k-1 = stage k)
//   rd, avail    : per-stage destination and bypassable-from stage, packed
//   byp_sel      : stage to bypass from, NONE when reading the RF
//   hazard       : youngest producer has not yet produced its result
module proc_hazard_match
  import proc_hazard_pkg::*;
#(
  parameter int NSTG = 3,
  parameter int AW   = 5,
  parameter int SW   = $clog2(NSTG + 1)
) (
  input  logic               en,
  input  logic [AW-1:0]      rs,
  input  logic [NSTG-1:0]    val,
  input  logic [NSTG-1:0]    wen,
  input  logic [NSTG*AW-1:0] rd,
  input  logic [NSTG*SW-1:0] avail,
  output logic [SW-1:0]      byp_sel,
  output logic               hazard
);

  logic          found;
  logic [SW-1:0] hit_k;
  logic [SW-1:0] hit_av;

  always_comb begin
    found   = 1'b0;
    hit_k   = SW'(NONE);
    hit_av  = SW'(NONE);
    byp_sel = SW'(NONE);
    hazard  = 1'b0;
    // Scan oldest to youngest so the last hit kept is the youngest producer.
    for (int k = NSTG; k >= 1; k--) begin
      if (val[k-1] && wen[k-1] && (rd[(k-1)*AW +: AW] == rs)) begin
        found  = 1'b1;
        hit_k  = SW'(k);
        hit_av = avail[(k-1)*SW +: SW];
      end
    end
    // x0 is hardwired zero and never needs forwarding.
    if (en && (rs != '0) && found) begin
      if (hit_k >= hit_av) byp_sel = hit_k;
      else                 hazard  = 1'b1;
    end
  end

endmodule

// File: rtl/proc_hazard_unit.sv
// proc_hazard_unit
// Tracks the destination of every in-flight instruction after decode (D),
// resolves operand bypassing and load-use stalls for the instruction in D,
// and propagates per-stage stalls, bubbles and redirect squashes.
//   clk, reset              : clock, synchronous active-high reset
//   val_D, rs*_D, rs*_en_D  : instruction in decode and its sources
//   rd_D, rf_wen_D, avail_D : its destination and bypass-availability stage
//   ostall_i                : per-stage originating stall (bit k-1 = stage k)
//   redir_val, redir_stg    : redirect from stage redir_stg
//   byp_sel_rs1/rs2         : bypass source stage per operand (0 = RF)
//   stall_D, squash_D       : decode control
//   reg_en                  : pipeline register enables (bit 0 = D)
//   val_o                   : per-stage valid
//   rf_wen_W, rf_waddr_W    : register-file write port of the last stage
//   commit_inst             : an instruction retires this cycle
//   stall_cnt, squash_cnt   : saturating statistics counters
module proc_hazard_unit
  import proc_hazard_pkg::*;
#(
  parameter int NSTG = 3,
  parameter int AW   = 5,
  parameter int SW   = $clog2(NSTG + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            val_D,
  input  logic [AW-1:0]   rs1_D,
  input  logic [AW-1:0]   rs2_D,
  input  logic            rs1_en_D,
  input  logic            rs2_en_D,
  input  logic [AW-1:0]   rd_D,
  input  logic            rf_wen_D,
  input  logic [SW-1:0]   avail_D,
  input  logic [NSTG-1:0] ostall_i,
  input  logic            redir_val,
  input  logic [SW-1:0]   redir_stg,
  output logic [SW-1:0]   byp_sel_rs1,
  output logic [SW-1:0]   byp_sel_rs2,
  output logic            stall_D,
  output logic            squash_D,
  output logic [NSTG:0]   reg_en,
  output logic [NSTG-1:0] val_o,
  output logic            rf_wen_W,
  output logic [AW-1:0]   rf_waddr_W,
  output logic            commit_inst,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     squash_cnt
);

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction

  // Per-stage entry, indexed by stage number (1 = X ... NSTG = W).
  logic [NSTG:1]  val_p;
  logic [NSTG:1]  wen_p;
  logic [AW-1:0]  rd_p    [1:NSTG];
  logic [SW-1:0]  avail_p [1:NSTG];

  logic [NSTG:1]      stall;
  logic [NSTG:1]      sq;
  logic [NSTG*AW-1:0] rd_v;
  logic [NSTG*SW-1:0] avail_v;
  logic               hz1;
  logic               hz2;
  logic               hazard_D;

  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall   = '0;
    sq      = '0;
    rd_v    = '0;
    avail_v = '0;
    // A stall anywhere downstream freezes every stage up to it.
    for (int k = NSTG; k >= 1; k--) begin
      acc      = acc | ostall_i[k-1];
      stall[k] = acc;
    end
    for (int k = 1; k <= NSTG; k++) begin
      sq[k]                  = redir_val && (SW'(k) < redir_stg);
      rd_v[(k-1)*AW +: AW]   = rd_p[k];
      avail_v[(k-1)*SW +: SW] = avail_p[k];
    end
  end

  proc_hazard_match #(.NSTG(NSTG), .AW(AW), .SW(SW)) u_match_rs1 (
    .en      (rs1_en_D),
    .rs      (rs1_D),
    .val     (val_p),
    .wen     (wen_p),
    .rd      (rd_v),
    .avail   (avail_v),
    .byp_sel (byp_sel_rs1),
    .hazard  (hz1)
  );

  proc_hazard_match #(.NSTG(NSTG), .AW(AW), .SW(SW)) u_match_rs2 (
    .en      (rs2_en_D),
    .rs      (rs2_D),
    .val     (val_p),
    .wen     (wen_p),
    .rd      (rd_v),
    .avail   (avail_v),
    .byp_sel (byp_sel_rs2),
    .hazard  (hz2)
  );

  // A redirect kills D anyway, so its hazard must not hold D in place.
  assign hazard_D = val_D && (hz1 || hz2);
  assign squash_D = redir_val;
  assign stall_D  = stall[1] || (hazard_D && !redir_val);

  always_comb begin
    reg_en    = '0;
    reg_en[0] = !stall_D || squash_D;
    for (int k = 1; k <= NSTG; k++) reg_en[k] = !stall[k] || sq[k];
  end

  assign val_o       = val_p;
  assign commit_inst = val_p[NSTG] && !stall[NSTG];
  assign rf_wen_W    = commit_inst && wen_p[NSTG];
  assign rf_waddr_W  = rd_p[NSTG];

  always_ff @(posedge clk) begin
    if (reset) begin
      val_p      <= '0;
      wen_p      <= '0;
      stall_cnt  <= '0;
      squash_cnt <= '0;
      for (int k = 1; k <= NSTG; k++) begin
        rd_p[k]    <= '0;
        avail_p[k] <= '0;
      end
    end else begin
      // D -> stage 1: a stalled or squashed D leaves a bubble behind.
      if (!stall[1]) begin
        val_p[1]   <= val_D && !stall_D && !squash_D;
        wen_p[1]   <= rf_wen_D;
        rd_p[1]    <= rd_D;
        avail_p[1] <= avail_D;
      end else if (sq[1]) begin
        val_p[1]   <= 1'b0;
      end
      // Stage k-1 -> stage k: bubble when k-1 is frozen but k drains, and
      // an entry squashed in k-1 arrives invalid.
      for (int k = 2; k <= NSTG; k++) begin
        if (!stall[k]) begin
          val_p[k]   <= val_p[k-1] && !stall[k-1] && !sq[k-1];
          wen_p[k]   <= wen_p[k-1];
          rd_p[k]    <= rd_p[k-1];
          avail_p[k] <= avail_p[k-1];
        end else if (sq[k]) begin
          val_p[k]   <= 1'b0;
        end
      end
      if (val_D && stall_D && !redir_val) stall_cnt <= sat_inc(stall_cnt);
      if (redir_val) squash_cnt <= sat_inc(squash_cnt);
    end
  end

endmodule

// File: tb/tb_proc_hazard_unit.sv
// tb_proc_hazard_unit
// Directed scenarios for the hazard unit (NSTG=3). Expected values for each
// cycle are queued when the stimulus is applied and compared on the falling
// edge; a second queue follows every instruction accepted from D and is
// compared against the register-file write port when it retires.
module tb_proc_hazard_unit;
  import proc_hazard_pkg::*;

  localparam int NSTG = 3;
  localparam int AW   = 5;
  localparam int SW   = 2;

  localparam int S_STALL  = 0;
  localparam int S_SQUASH = 1;
  localparam int S_BYP1   = 2;
  localparam int S_BYP2   = 3;
  localparam int S_VALO   = 4;
  localparam int S_VALO0  = 5;
  localparam int S_COMMIT = 6;
  localparam int S_RFWEN  = 7;
  localparam int S_STCNT  = 8;
  localparam int S_SQCNT  = 9;
  localparam int S_REGEN  = 10;

  logic            clk = 1'b0;
  logic            reset;
  logic            val_D;
  logic [AW-1:0]   rs1_D, rs2_D, rd_D;
  logic            rs1_en_D, rs2_en_D, rf_wen_D;
  logic [SW-1:0]   avail_D;
  logic [NSTG-1:0] ostall_i;
  logic            redir_val;
  logic [SW-1:0]   redir_stg;
  logic [SW-1:0]   byp_sel_rs1, byp_sel_rs2;
  logic            stall_D, squash_D;
  logic [NSTG:0]   reg_en;
  logic [NSTG-1:0] val_o;
  logic            rf_wen_W;
  logic [AW-1:0]   rf_waddr_W;
  logic            commit_inst;
  logic [31:0]     stall_cnt, squash_cnt;

  always #5 clk = ~clk;

  proc_hazard_unit #(.NSTG(NSTG), .AW(AW), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .val_D       (val_D),
    .rs1_D       (rs1_D),
    .rs2_D       (rs2_D),
    .rs1_en_D    (rs1_en_D),
    .rs2_en_D    (rs2_en_D),
    .rd_D        (rd_D),
    .rf_wen_D    (rf_wen_D),
    .avail_D     (avail_D),
    .ostall_i    (ostall_i),
    .redir_val   (redir_val),
    .redir_stg   (redir_stg),
    .byp_sel_rs1 (byp_sel_rs1),
    .byp_sel_rs2 (byp_sel_rs2),
    .stall_D     (stall_D),
    .squash_D    (squash_D),
    .reg_en      (reg_en),
    .val_o       (val_o),
    .rf_wen_W    (rf_wen_W),
    .rf_waddr_W  (rf_waddr_W),
    .commit_inst (commit_inst),
    .stall_cnt   (stall_cnt),
    .squash_cnt  (squash_cnt)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [AW-1:0] rd;
    logic          wen;
  } ci_t;
  ci_t cq[$];

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_STALL:  return 32'(stall_D);
      S_SQUASH: return 32'(squash_D);
      S_BYP1:   return 32'(byp_sel_rs1);
      S_BYP2:   return 32'(byp_sel_rs2);
      S_VALO:   return 32'(val_o);
      S_VALO0:  return 32'(val_o[0]);
      S_COMMIT: return 32'(commit_inst);
      S_RFWEN:  return 32'(rf_wen_W);
      S_STCNT:  return stall_cnt;
      S_SQCNT:  return squash_cnt;
      S_REGEN:  return 32'(reg_en);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Compare queued expectations mid-cycle, then advance past the next edge.
  task automatic settle();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, actual(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [AW-1:0] r1, input logic e1,
                     input logic [AW-1:0] r2, input logic e2,
                     input logic [AW-1:0] rd, input logic w, input logic [SW-1:0] av);
    val_D    = v;
    rs1_D    = r1;
    rs1_en_D = e1;
    rs2_D    = r2;
    rs2_en_D = e2;
    rd_D     = rd;
    rf_wen_D = w;
    avail_D  = av;
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic flush();
    idle();
    repeat (4) settle();
  endtask

  // Retirement scoreboard.
  always @(negedge clk) begin
    ci_t c;
    if (reset) begin
      cq.delete();
    end else begin
      if (commit_inst) begin
        check_eq("sb_nonempty", 32'(cq.size() != 0), 32'd1);
        if (cq.size() != 0) begin
          c = cq.pop_front();
          check_eq("commit_rd", 32'(rf_waddr_W), 32'(c.rd));
          check_eq("commit_wen", 32'(rf_wen_W), 32'(c.wen));
        end
      end
      if (val_D && !stall_D && !squash_D) begin
        c.rd  = rd_D;
        c.wen = rf_wen_D;
        cq.push_back(c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran past its time limit");
    $fatal(1, "watchdog expired");
  end

  localparam logic [SW-1:0] AX = 2'(AVAIL_X);
  localparam logic [SW-1:0] AM = 2'(AVAIL_M);

  initial begin
    reset     = 1'b1;
    ostall_i  = '0;
    redir_val = 1'b0;
    redir_stg = '0;
    idle();
    @(posedge clk);
    #1;
    settle();
    settle();
    reset = 1'b0;

    // Reset state
    expect_v("rst_val_o", S_VALO, 32'd0);
    expect_v("rst_commit", S_COMMIT, 32'd0);
    expect_v("rst_rf_wen", S_RFWEN, 32'd0);
    expect_v("rst_byp1", S_BYP1, 32'd0);
    expect_v("rst_byp2", S_BYP2, 32'd0);
    expect_v("rst_stcnt", S_STCNT, 32'd0);
    expect_v("rst_sqcnt", S_SQCNT, 32'd0);
    settle();

    // ALU result in X bypassed to D
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, AX);
    expect_v("add_issue_stall", S_STALL, 32'd0);
    settle();
    drv(1'b1, 5'd3, 1'b1, '0, 1'b0, 5'd4, 1'b1, AX);
    expect_v("alu_byp1", S_BYP1, 32'd1);
    expect_v("alu_stall", S_STALL, 32'd0);
    settle();
    flush();

    // Load-use: one stall, then bypass from M
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, AM);
    settle();
    drv(1'b1, '0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, AX);
    expect_v("lu_stall", S_STALL, 32'd1);
    expect_v("lu_byp2_stalled", S_BYP2, 32'd0);
    expect_v("lu_regen", S_REGEN, 32'b1110);
    settle();
    expect_v("lu_stall_after", S_STALL, 32'd0);
    expect_v("lu_byp2_m", S_BYP2, 32'd2);
    expect_v("lu_stcnt", S_STCNT, 32'd1);
    settle();
    flush();

    // Youngest producer wins; x0 never bypasses
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, AX);
    settle();
    settle();
    drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, AX);
    expect_v("young_byp1", S_BYP1, 32'd1);
    expect_v("young_byp2", S_BYP2, 32'd1);
    expect_v("young_stall", S_STALL, 32'd0);
    settle();
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0, AX);
    expect_v("x0_byp1", S_BYP1, 32'd0);
    expect_v("x0_byp2", S_BYP2, 32'd0);
    expect_v("x0_stall", S_STALL, 32'd0);
    settle();
    flush();

    // Redirect beats a load-use hazard in D
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd9, 1'b1, AM);
    settle();
    drv(1'b1, 5'd9, 1'b1, '0, 1'b0, 5'd10, 1'b1, AX);
    redir_val = 1'b1;
    redir_stg = 2'd1;
    expect_v("redir_squash", S_SQUASH, 32'd1);
    expect_v("redir_stall", S_STALL, 32'd0);
    expect_v("redir_sqcnt_pre", S_SQCNT, 32'd0);
    settle();
    redir_val = 1'b0;
    redir_stg = '0;
    idle();
    expect_v("redir_val0", S_VALO0, 32'd0);
    expect_v("redir_val_o", S_VALO, 32'b010);
    expect_v("redir_sqcnt", S_SQCNT, 32'd1);
    expect_v("redir_stcnt", S_STCNT, 32'd1);
    expect_v("redir_squash_off", S_SQUASH, 32'd0);
    settle();
    flush();

    // Stall originating in M: X and D frozen, W drains into bubbles
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd10, 1'b1, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd11, 1'b1, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd12, 1'b0, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd13, 1'b1, AX);
    ostall_i = 3'b010;
    expect_v("ms_stall1", S_STALL, 32'd1);
    expect_v("ms_regen1", S_REGEN, 32'b1000);
    expect_v("ms_commit1", S_COMMIT, 32'd1);
    expect_v("ms_stcnt1", S_STCNT, 32'd1);
    settle();
    expect_v("ms_stall2", S_STALL, 32'd1);
    expect_v("ms_commit2", S_COMMIT, 32'd0);
    expect_v("ms_val_o2", S_VALO, 32'b011);
    expect_v("ms_stcnt2", S_STCNT, 32'd2);
    settle();
    ostall_i = '0;
    expect_v("ms_stall3", S_STALL, 32'd0);
    expect_v("ms_commit3", S_COMMIT, 32'd0);
    expect_v("ms_val_o3", S_VALO, 32'b011);
    expect_v("ms_stcnt3", S_STCNT, 32'd3);
    expect_v("ms_regen3", S_REGEN, 32'b1111);
    settle();
    flush();

    // Reset mid-operation beats advance, stall and redirect
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd20, 1'b1, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd21, 1'b1, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd22, 1'b1, AX);
    settle();
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd23, 1'b1, AX);
    reset     = 1'b1;
    ostall_i  = 3'b001;
    redir_val = 1'b1;
    redir_stg = 2'd2;
    expect_v("mid_val_o_pre", S_VALO, 32'b111);
    settle();
    reset     = 1'b0;
    ostall_i  = '0;
    redir_val = 1'b0;
    redir_stg = '0;
    idle();
    expect_v("mid_val_o", S_VALO, 32'd0);
    expect_v("mid_commit", S_COMMIT, 32'd0);
    expect_v("mid_rf_wen", S_RFWEN, 32'd0);
    expect_v("mid_stcnt", S_STCNT, 32'd0);
    expect_v("mid_sqcnt", S_SQCNT, 32'd0);
    expect_v("mid_byp1", S_BYP1, 32'd0);
    settle();
    flush();

    check_eq("sb_drained", 32'(cq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
